// File: rtl/toggle_event_rx.sv
// Receiver for a toggle-signalled event line: synchronises tog_in, turns every level change into
// one event, queues events in a saturating counter and hands them out over valid/ready.
module toggle_event_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TOT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tog_in,
  input  logic             en,
  input  logic             evt_ready,
  input  logic             clr_ovf,
  output logic             evt_valid,
  output logic [CNT_W-1:0] pending,
  output logic [TOT_W-1:0] total,
  output logic             overflow,
  output logic             armed
);

  localparam int unsigned InitW = (SYNC_STAGES > 2) ? $clog2(SYNC_STAGES) : 1;
  localparam logic [InitW-1:0] InitLast = InitW'(SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] PendMax  = '1;

  typedef enum logic {StInit, StRun} state_e;

  state_e                 state_q, state_d;
  logic [InitW-1:0]       init_cnt_q, init_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic [TOT_W-1:0]       total_q, total_d;
  logic                   overflow_q, overflow_d;
  logic                   armed_q, armed_d;
  logic                   toggle, inc, dec, lost;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    last_d     = last_q;
    armed_d    = armed_q;
    toggle     = 1'b0;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == InitLast) begin
          // Take the level that sync_out shows after this edge, so the idle line is not an event.
          last_d  = sync_q[SYNC_STAGES-2];
          state_d = StRun;
          armed_d = 1'b1;
        end
      end
      StRun: begin
        toggle = sync_out ^ last_q;
        last_d = sync_out;
      end
    endcase
  end

  always_comb begin
    inc        = toggle & en;
    dec        = evt_valid & evt_ready;
    lost       = 1'b0;
    pending_d  = pending_q;
    total_d    = total_q;
    overflow_d = overflow_q;
    if (inc) begin
      total_d = total_q + 1'b1;
    end
    if (inc && !dec) begin
      if (pending_q == PendMax) begin
        lost = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (!inc && dec) begin
      pending_d = pending_q - 1'b1;
    end
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (lost) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      sync_q     <= '0;
      last_q     <= 1'b0;
      pending_q  <= '0;
      total_q    <= '0;
      overflow_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], tog_in};
      last_q     <= last_d;
      pending_q  <= pending_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
      armed_q    <= armed_d;
    end
  end

  assign evt_valid = (pending_q != '0);
  assign pending   = pending_q;
  assign total     = total_q;
  assign overflow  = overflow_q;
  assign armed     = armed_q;

endmodule
